snake_dir_ctrl: RTL and testbench
=================================

// Module: snake_dir_ctrl
// PURPOSE
//   Downstream consumer of the PS/2 receiver's keycode[7:0] and newkeyStrobe.
//   Parses PS/2 set-2 byte sequences (E0 extend, F0 break) into snake direction
//   commands, buffers them in a small FIFO, and applies one command per game tick.
//   Rejects 180-degree reversals and handles the pause key for the game engine.
// PARAMETERS
//   DEPTH   4   direction FIFO entries (power of 2, >=2)
//   AW      2   FIFO address width, log2(DEPTH)
// PORTS
//   CLK           in   1  system clock
//   RST           in   1  asynchronous reset, active-high
//   keycode       in   8  last received PS/2 byte, stable while newkeyStrobe=1
//   newkeyStrobe  in   1  one-CLK pulse per received byte
//   tick          in   1  one-CLK game-step pulse
//   dir           out  2  current direction: 0=UP 1=RIGHT 2=DOWN 3=LEFT
//   dir_changed   out  1  one-CLK pulse, cycle after dir updates
//   paused        out  1  pause state, toggled by space make
//   overflow      out  1  sticky: a command was dropped because the FIFO was full
//   fifo_count    out  AW+1  entries currently queued
// BEHAVIOUR
//   Reset (async, RST=1): dir=RIGHT, dir_changed=0, paused=0, overflow=0,
//     FIFO empty, parser in IDLE. RST mid-sequence discards partial codes.
//   Parser FSM advances only on CLK edges where newkeyStrobe=1:
//     IDLE:    E0->EXT; F0->BRK; 29 (space)->toggle paused, stay IDLE; else IDLE
//     EXT:     F0->EXT_BRK; E0->EXT; 75/74/72/6B->push UP/RIGHT/DOWN/LEFT, IDLE;
//              any other byte->IDLE
//     BRK:     any byte->IDLE (break consumed, no action)
//     EXT_BRK: any byte->IDLE
//   Push rules (same edge as final make byte; fifo_count updates next cycle):
//     - suppress if equal to tail entry, or to dir when FIFO empty
//       (typematic repeats collapse)
//     - if full and no pop on that edge: drop, set overflow=1
//   Pop rules: on tick=1 while paused=0 and FIFO non-empty, pop head:
//     - head == dir^2'b10 (reversal): discard, dir unchanged, no pulse
//     - otherwise dir<=head and dir_changed=1 on the next cycle
//     - tick while paused or FIFO empty: no effect
//   Simultaneous push+pop on one edge: both occur, count unchanged,
//     full FIFO accepts the push (no overflow).
//   Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
//   Pause toggle and tick on the same edge: tick uses the pre-toggle paused value.
// CONFIGURATION
//   SNAKE_WASD_EN defined: IDLE also accepts make codes 1D/1B/1C/23 as
//     UP/DOWN/LEFT/RIGHT, pushed under the same rules.
//   Undefined: those bytes are ignored (IDLE->IDLE), arrows only.
// STRUCTURE
//   Shared include snake_defs.vh: direction encodings, keycode constants
//   (E0, F0, 29, arrow and WASD codes), parser state encodings.
//   Sub-module dir_fifo (DEPTH x 2-bit, push/pop/full/empty/count/tail);
//   parser FSM and apply logic live in snake_dir_ctrl.
// TESTING
//   Reset, then E0,75 strobes, then tick -> dir=UP, dir_changed pulse once, count 1->0.
//   dir=RIGHT; E0,6B, then tick -> head LEFT discarded, dir stays RIGHT, no pulse.
//   E0,72 x3 (typematic) -> fifo_count=1; E0,F0,72 break -> count stays 1.
//   Five distinct alternating pushes, no tick (DEPTH=4) -> count=4, overflow=1;
//     push+tick on same edge while full -> count stays 4.
//   29 strobe -> paused=1; tick with queued UP -> dir unchanged; 29 again,
//     tick -> dir=UP.
//   SNAKE_WASD_EN: 1D then tick -> dir=UP; without macro -> count stays 0.
//   Assert RST after E0 only, release, send 75 -> no push, parser in IDLE.

Source files
------------

// File: rtl/snake_dir_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// snake_dir_ctrl_pkg
//   Shared definitions for the snake direction controller:
//   - direction encodings (0=UP 1=RIGHT 2=DOWN 3=LEFT)
//   - PS/2 set-2 keycode constants (prefixes, space, arrows, WASD)
//   - parser state encoding (also visible on the debug output)
//   - helper that gives the opposite direction of a heading
// ----------------------------------------------------------------------------
package snake_dir_ctrl_pkg;

  // Direction encodings.  Opposite directions differ only in bit 1.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // PS/2 set-2 bytes.
  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BRK   = 8'hF0;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] KC_UP    = 8'h75;
  localparam logic [7:0] KC_RIGHT = 8'h74;
  localparam logic [7:0] KC_DOWN  = 8'h72;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_W     = 8'h1D;
  localparam logic [7:0] KC_S     = 8'h1B;
  localparam logic [7:0] KC_A     = 8'h1C;
  localparam logic [7:0] KC_D     = 8'h23;

  // Parser states.
  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_EXT     = 2'd1,
    P_BRK     = 2'd2,
    P_EXT_BRK = 2'd3
  } parser_state_e;

  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_dir_fifo.sv
// ----------------------------------------------------------------------------
// dir_fifo
//   DEPTH x 2-bit direction FIFO.  Pop on an empty FIFO is ignored; push on a
//   full FIFO is accepted only when a pop happens on the same edge.
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     push_i, din_i  push request and data
//     pop_i          pop request
//     head_o         oldest entry (valid when !empty_o)
//     tail_o         newest entry (valid when !empty_o)
//     full_o/empty_o occupancy flags
//     count_o        entries queued, 0..DEPTH
// ----------------------------------------------------------------------------
module dir_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [1:0]    din_i,
  input  logic          pop_i,
  output logic [1:0]    head_o,
  output logic [1:0]    tail_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the same edge frees a slot.
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o  = mem_q[rd_q];
  assign tail_o  = mem_q[wr_q - AW'(1)];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push) wr_q <= wr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// ----------------------------------------------------------------------------
// snake_dir_ctrl
//   Turns PS/2 set-2 bytes into snake direction commands, queues them and
//   applies one per game tick, discarding 180-degree reversals.  Space toggles
//   pause.  Build macro SNAKE_WASD_EN additionally accepts W/A/S/D make codes.
//   Ports:
//     CLK, RST      clock, asynchronous active-high reset
//     keycode       received byte, valid while newkeyStrobe=1
//     newkeyStrobe  one-cycle pulse per received byte
//     tick          one-cycle game-step pulse
//     dir           current heading (0=UP 1=RIGHT 2=DOWN 3=LEFT)
//     dir_changed   one-cycle pulse, high in the cycle dir shows a new value
//     paused        pause state
//     overflow      sticky: a command was dropped on a full queue
//     fifo_count    entries queued
//     parser_state  debug view of the byte parser state
//   Handshake: no backpressure; a byte is consumed on every edge where
//   newkeyStrobe=1, a tick is consumed on every edge where tick=1.
// ----------------------------------------------------------------------------
module snake_dir_ctrl
  import snake_dir_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    keycode,
  input  logic          newkeyStrobe,
  input  logic          tick,
  output logic [1:0]    dir,
  output logic          dir_changed,
  output logic          paused,
  output logic          overflow,
  output logic [AW:0]   fifo_count,
  output logic [1:0]    parser_state
);

  parser_state_e state_q, state_d;
  logic          paused_q, paused_d;
  logic [1:0]    dir_q;
  logic          dir_changed_q;
  logic          overflow_q;

  logic          push_req;
  logic [1:0]    push_dir;
  logic          push_ok;
  logic          pop;
  logic [1:0]    fifo_head, fifo_tail;
  logic          fifo_full, fifo_empty;
  logic [1:0]    last_cmd;

  // Byte decode: next parser state, pause toggle and any direction command.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    push_req = 1'b0;
    push_dir = DIR_UP;
    if (newkeyStrobe) begin
      case (state_q)
        P_IDLE: begin
          if (keycode == KC_EXT)        state_d  = P_EXT;
          else if (keycode == KC_BRK)   state_d  = P_BRK;
          else if (keycode == KC_SPACE) paused_d = !paused_q;
`ifdef SNAKE_WASD_EN
          else if (keycode == KC_W) begin push_req = 1'b1; push_dir = DIR_UP;    end
          else if (keycode == KC_S) begin push_req = 1'b1; push_dir = DIR_DOWN;  end
          else if (keycode == KC_A) begin push_req = 1'b1; push_dir = DIR_LEFT;  end
          else if (keycode == KC_D) begin push_req = 1'b1; push_dir = DIR_RIGHT; end
`endif
        end
        P_EXT: begin
          state_d = P_IDLE;
          if (keycode == KC_BRK)        state_d = P_EXT_BRK;
          else if (keycode == KC_EXT)   state_d = P_EXT;
          else if (keycode == KC_UP)    begin push_req = 1'b1; push_dir = DIR_UP;    end
          else if (keycode == KC_RIGHT) begin push_req = 1'b1; push_dir = DIR_RIGHT; end
          else if (keycode == KC_DOWN)  begin push_req = 1'b1; push_dir = DIR_DOWN;  end
          else if (keycode == KC_LEFT)  begin push_req = 1'b1; push_dir = DIR_LEFT;  end
        end
        // Byte after a break prefix is the released key: swallow it.
        default: state_d = P_IDLE;
      endcase
    end
  end

  // Typematic repeats collapse against the newest pending command, or the
  // live heading when nothing is pending.
  assign last_cmd = fifo_empty ? dir_q : fifo_tail;
  assign push_ok  = push_req && (push_dir != last_cmd);
  // Tick sees the pause value from before any same-edge toggle.
  assign pop      = tick && !paused_q && !fifo_empty;

  dir_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_ok),
    .din_i   (push_dir),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .tail_o  (fifo_tail),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= P_IDLE;
      paused_q      <= 1'b0;
      dir_q         <= DIR_RIGHT;
      dir_changed_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      paused_q      <= paused_d;
      dir_changed_q <= 1'b0;
      // A popped reversal is dropped silently.
      if (pop && (fifo_head != opposite_dir(dir_q))) begin
        dir_q         <= fifo_head;
        dir_changed_q <= 1'b1;
      end
      if (push_ok && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign dir          = dir_q;
  assign dir_changed  = dir_changed_q;
  assign paused       = paused_q;
  assign overflow     = overflow_q;
  assign parser_state = state_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// ----------------------------------------------------------------------------
// tb_snake_dir_ctrl
//   Directed scenarios followed by random byte/tick traffic, all compared to a
//   queue-based reference model of the controller after every clock.
// ----------------------------------------------------------------------------
module tb_snake_dir_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [7:0]    keycode = 8'h00;
  logic          newkeyStrobe = 1'b0;
  logic          tick = 1'b0;
  logic [1:0]    dir;
  logic          dir_changed;
  logic          paused;
  logic          overflow;
  logic [AW:0]   fifo_count;
  logic [1:0]    parser_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  snake_dir_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .keycode      (keycode),
    .newkeyStrobe (newkeyStrobe),
    .tick         (tick),
    .dir          (dir),
    .dir_changed  (dir_changed),
    .paused       (paused),
    .overflow     (overflow),
    .fifo_count   (fifo_count),
    .parser_state (parser_state)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 after E0, 2 after F0, 3 after E0 F0
  logic [1:0] exp_q[$];
  int         m_dir;
  bit         m_changed;
  bit         m_paused;
  bit         m_overflow;
  int         m_mode;

  task automatic model_reset();
    exp_q.delete();
    m_dir      = 1;
    m_changed  = 0;
    m_paused   = 0;
    m_overflow = 0;
    m_mode     = 0;
  endtask

  function automatic int arrow_dir(input logic [7:0] kc);
    case (kc)
      8'h75:   return 0;
      8'h74:   return 1;
      8'h72:   return 2;
      8'h6B:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_dir(input logic [7:0] kc);
`ifdef SNAKE_WASD_EN
    case (kc)
      8'h1D:   return 0;
      8'h1B:   return 2;
      8'h1C:   return 3;
      8'h23:   return 1;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  task automatic model_step(input logic [7:0] kc, input bit stb, input bit tk);
    int  pre_dir, pre_n, want, last, h;
    bit  pre_paused, do_pop;
    pre_dir    = m_dir;
    pre_paused = m_paused;
    pre_n      = exp_q.size();
    do_pop     = tk && !pre_paused && (pre_n > 0);
    want       = -1;
    m_changed  = 0;
    if (stb) begin
      if (m_mode == 0) begin
        if (kc == 8'hE0)      m_mode = 1;
        else if (kc == 8'hF0) m_mode = 2;
        else if (kc == 8'h29) m_paused = !m_paused;
        else                  want = wasd_dir(kc);
      end else if (m_mode == 1) begin
        if (kc == 8'hF0)      m_mode = 3;
        else if (kc == 8'hE0) m_mode = 1;
        else begin
          want   = arrow_dir(kc);
          m_mode = 0;
        end
      end else begin
        m_mode = 0;
      end
    end
    if (want >= 0) begin
      last = (pre_n == 0) ? pre_dir : int'(exp_q[pre_n-1]);
      if (want == last) want = -1;
    end
    if (do_pop) begin
      h = int'(exp_q.pop_front());
      if (h != (pre_dir + 2) % 4) begin
        m_dir     = h;
        m_changed = 1;
      end
    end
    if (want >= 0) begin
      if (pre_n < DEPTH || do_pop) exp_q.push_back(2'(want));
      else                         m_overflow = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("dir",          32'(dir),          32'(m_dir));
    check_eq("dir_changed",  32'(dir_changed),  32'(m_changed));
    check_eq("paused",       32'(paused),       32'(m_paused));
    check_eq("overflow",     32'(overflow),     32'(m_overflow));
    check_eq("fifo_count",   32'(fifo_count),   32'(exp_q.size()));
    check_eq("parser_state", 32'(parser_state), 32'(m_mode));
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [7:0] kc, input bit stb, input bit tk);
    keycode      = kc;
    newkeyStrobe = stb;
    tick         = tk;
    model_step(kc, stb, tk);
    @(posedge CLK);
    #1;
    newkeyStrobe = 1'b0;
    tick         = 1'b0;
    @(negedge CLK);
    check_model();
  endtask

  task automatic send(input logic [7:0] kc);
    step(kc, 1'b1, 1'b0);
  endtask

  task automatic do_tick();
    step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    check_model();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pool [12];

  initial begin
    pool = '{8'hE0, 8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B,
             8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Reset values.
    RST = 1'b0;
    check_eq("rst_dir",      32'(dir),        32'd1);
    check_eq("rst_changed",  32'(dir_changed), 32'd0);
    check_eq("rst_paused",   32'(paused),     32'd0);
    check_eq("rst_overflow", 32'(overflow),   32'd0);
    check_eq("rst_count",    32'(fifo_count), 32'd0);
    check_model();

    // Arrow up then tick.
    send(8'hE0); send(8'h75);
    check_eq("up_queued", 32'(fifo_count), 32'd1);
    do_tick();
    check_eq("up_dir",   32'(dir),         32'd0);
    check_eq("up_pulse", 32'(dir_changed), 32'd1);
    check_eq("up_count", 32'(fifo_count),  32'd0);
    idle();
    check_eq("up_pulse_end", 32'(dir_changed), 32'd0);

    // Back to RIGHT, then a LEFT reversal must be discarded.
    send(8'hE0); send(8'h74); do_tick();
    send(8'hE0); send(8'h6B); do_tick();
    check_eq("rev_dir",   32'(dir),         32'd1);
    check_eq("rev_pulse", 32'(dir_changed), 32'd0);
    check_eq("rev_count", 32'(fifo_count),  32'd0);

    // Typematic repeats and a break sequence.
    repeat (3) begin send(8'hE0); send(8'h72); end
    check_eq("typematic_count", 32'(fifo_count), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h72);
    check_eq("break_count", 32'(fifo_count), 32'd1);
    do_tick();
    check_eq("down_dir", 32'(dir), 32'd2);

    // Overflow: five alternating pushes into a 4-deep queue.
    for (int i = 0; i < 5; i++) begin
      send(8'hE0);
      send((i % 2 == 0) ? 8'h75 : 8'h74);
    end
    check_eq("ovf_count", 32'(fifo_count), 32'd4);
    check_eq("ovf_flag",  32'(overflow),   32'd1);
    send(8'hE0);
    step(8'h6B, 1'b1, 1'b1);
    check_eq("full_pushpop_count", 32'(fifo_count), 32'd4);
    repeat (5) do_tick();

    // Pause.
    do_reset();
    send(8'h29);
    check_eq("pause_on", 32'(paused), 32'd1);
    send(8'hE0); send(8'h75);
    do_tick();
    check_eq("pause_dir",   32'(dir),        32'd1);
    check_eq("pause_count", 32'(fifo_count), 32'd1);
    send(8'h29);
    do_tick();
    check_eq("unpause_dir", 32'(dir), 32'd0);

    // WASD.
    do_reset();
    send(8'h1D);
`ifdef SNAKE_WASD_EN
    check_eq("wasd_count", 32'(fifo_count), 32'd1);
    do_tick();
    check_eq("wasd_dir", 32'(dir), 32'd0);
`else
    check_eq("wasd_count", 32'(fifo_count), 32'd0);
    do_tick();
    check_eq("wasd_dir", 32'(dir), 32'd1);
`endif

    // Reset in the middle of an extended sequence.
    do_reset();
    send(8'hE0);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    send(8'h75);
    check_eq("midrst_count", 32'(fifo_count),   32'd0);
    check_eq("midrst_state", 32'(parser_state), 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] kc;
      bit stb, tk;
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) kc = 8'($urandom_range(0, 255));
      else kc = pool[$urandom_range(0, 10 + (($urandom_range(0, 7) == 0) ? 1 : 0))];
      stb = ($urandom_range(0, 99) < 60);
      tk  = ($urandom_range(0, 99) < 25);
      step(kc, stb, tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-time bound in case the stimulus stalls.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
